// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the store commit buffer: entry layout, access sizes, FSM states and
// the byte-lane formatter that the STQ/LSU reuse.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef STQ_WIDTH
`define STQ_WIDTH 4
`endif

package store_commit_buffer_pkg;

   localparam int unsigned XLEN      = `XLEN;
   localparam int unsigned STQ_WIDTH = `STQ_WIDTH;

   typedef enum logic [1:0] {
      MemByte = 2'd0,
      MemHalf = 2'd1,
      MemWord = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait
   } sb_state_e;

   typedef struct packed {
      logic [XLEN-3:0]      word_addr;
      logic [31:0]          data;
      logic [3:0]           be;
      logic [STQ_WIDTH-1:0] stq_tag;
   } sb_entry_t;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] data;
   } lane_t;

   // Half and word accesses are forced onto their natural alignment; size 3 acts as word.
   function automatic lane_t lane_format(input logic [1:0] size, input logic [1:0] addr_lo,
                                         input logic [31:0] data);
      lane_t      r;
      logic [1:0] off;
      case (size)
         MemByte: begin
            off    = addr_lo;
            r.be   = 4'b0001 << off;
            r.data = {24'b0, data[7:0]} << {off, 3'b000};
         end
         MemHalf: begin
            off    = {addr_lo[1], 1'b0};
            r.be   = 4'b0011 << off;
            r.data = {16'b0, data[15:0]} << {off, 3'b000};
         end
         default: begin
            r.be   = 4'hF;
            r.data = data;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/store_commit_buffer_sb_fifo.sv
// In-order store buffer storage: wrap-bit pointers, full/empty, head read and per-entry
// word address / byte enables for the load probe.
module sb_fifo
   import store_commit_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push,
   input  sb_entry_t                       push_entry,
   input  logic                            pop,
   output sb_entry_t                       head,
   output logic                            full,
   output logic                            empty,
   output logic [DEPTH-1:0]                ent_valid,
   output logic [DEPTH-1:0][XLEN-3:0]      ent_word_addr,
   output logic [DEPTH-1:0][3:0]           ent_be
);

   sb_entry_t        mem_q [DEPTH];
   logic [WIDTH:0]   wr_ptr_q, rd_ptr_q;
   logic [WIDTH:0]   count;
   logic [WIDTH-1:0] offset [DEPTH];

   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == (WIDTH+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem_q[rd_ptr_q[WIDTH-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wr_ptr_q[WIDTH-1:0]] <= push_entry;
   end

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         offset[i]        = WIDTH'(i) - rd_ptr_q[WIDTH-1:0];
         ent_valid[i]     = ({1'b0, offset[i]} < count);
         ent_word_addr[i] = mem_q[i].word_addr;
         ent_be[i]        = mem_q[i].be;
      end
   end

endmodule

// File: rtl/store_commit_buffer.sv
// Drains retired stores from the STQ into the dcache, one write outstanding at a time.
// Optional SB_PROBE_BYTE_EN: load probe also requires byte-enable overlap.
module store_commit_buffer
   import store_commit_buffer_pkg::*;
#(
   parameter int unsigned SB_DEPTH = 4,
   parameter int unsigned SB_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fire_st_valid,
   output logic                  fire_st_ready,
   input  logic [`XLEN-1:0]      fire_st_addr,
   input  logic [`XLEN-1:0]      fire_st_data,
   input  logic [2:0]            fire_st_data_size,
   input  logic [`STQ_WIDTH-1:0] fire_st_stq_tag,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [`XLEN-1:0]      mem_req_addr,
   output logic [31:0]           mem_req_data,
   output logic [3:0]            mem_req_be,
   input  logic                  mem_resp_valid,
   output logic                  st_done_valid,
   output logic [`STQ_WIDTH-1:0] st_done_stq_tag,
   input  logic                  probe_valid,
   input  logic [`XLEN-1:0]      probe_addr,
   input  logic [2:0]            probe_size,
   output logic                  probe_hit,
   output logic                  sb_empty
);

   sb_state_e                        state_q;
   sb_entry_t                        push_entry, head;
   lane_t                            push_lane;
   logic                             full, empty, pop;
   logic [SB_DEPTH-1:0]              ent_valid, be_hit;
   logic [SB_DEPTH-1:0][XLEN-3:0]    ent_word_addr;
   logic [SB_DEPTH-1:0][3:0]         ent_be;
   logic                             unused_bits;

   assign push_lane  = lane_format(fire_st_data_size[1:0], fire_st_addr[1:0], fire_st_data);
   assign push_entry = '{word_addr: fire_st_addr[XLEN-1:2], data: push_lane.data,
                         be: push_lane.be, stq_tag: fire_st_stq_tag};

   assign fire_st_ready = !full;
   assign pop           = (state_q == StWait) && mem_resp_valid;
   assign sb_empty      = empty && (state_q == StIdle);

   sb_fifo #(
      .DEPTH (SB_DEPTH),
      .WIDTH (SB_WIDTH)
   ) u_sb_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push          (fire_st_valid && fire_st_ready),
      .push_entry    (push_entry),
      .pop           (pop),
      .head          (head),
      .full          (full),
      .empty         (empty),
      .ent_valid     (ent_valid),
      .ent_word_addr (ent_word_addr),
      .ent_be        (ent_be)
   );

   // The head stays in the FIFO through REQ and WAIT so it remains visible to the probe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         mem_req_valid   <= 1'b0;
         mem_req_addr    <= '0;
         mem_req_data    <= '0;
         mem_req_be      <= '0;
         st_done_valid   <= 1'b0;
         st_done_stq_tag <= '0;
      end else begin
         st_done_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!empty) begin
                  state_q       <= StReq;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {head.word_addr, 2'b00};
                  mem_req_data  <= head.data;
                  mem_req_be    <= head.be;
               end
            end
            StReq: begin
               if (mem_req_ready) begin
                  state_q       <= StWait;
                  mem_req_valid <= 1'b0;
               end
            end
            StWait: begin
               if (mem_resp_valid) begin
                  state_q         <= StIdle;
                  st_done_valid   <= 1'b1;
                  st_done_stq_tag <= head.stq_tag;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef SB_PROBE_BYTE_EN
   lane_t probe_lane;
   assign probe_lane = lane_format(probe_size[1:0], probe_addr[1:0], '0);
   always_comb begin
      for (int i = 0; i < SB_DEPTH; i++) be_hit[i] = |(ent_be[i] & probe_lane.be);
   end
   assign unused_bits = ^{probe_size[2], probe_lane.data, fire_st_data_size[2]};
`else
   assign be_hit      = '1;
   assign unused_bits = ^{probe_size, probe_addr[1:0], ent_be, fire_st_data_size[2]};
`endif

   always_comb begin
      probe_hit = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (ent_valid[i] && be_hit[i] && (ent_word_addr[i] == probe_addr[XLEN-1:2])) begin
            probe_hit = 1'b1;
         end
      end
      probe_hit = probe_hit && probe_valid;
   end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer.
module tb_store_commit_buffer;
   import store_commit_buffer_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 fire_st_valid = 1'b0;
   logic                 fire_st_ready;
   logic [XLEN-1:0]      fire_st_addr = '0;
   logic [XLEN-1:0]      fire_st_data = '0;
   logic [2:0]           fire_st_data_size = '0;
   logic [STQ_WIDTH-1:0] fire_st_stq_tag = '0;
   logic                 mem_req_valid;
   logic                 mem_req_ready = 1'b0;
   logic [XLEN-1:0]      mem_req_addr;
   logic [31:0]          mem_req_data;
   logic [3:0]           mem_req_be;
   logic                 mem_resp_valid = 1'b0;
   logic                 st_done_valid;
   logic [STQ_WIDTH-1:0] st_done_stq_tag;
   logic                 probe_valid = 1'b0;
   logic [XLEN-1:0]      probe_addr = '0;
   logic [2:0]           probe_size = '0;
   logic                 probe_hit;
   logic                 sb_empty;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   store_commit_buffer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fire_st_valid     (fire_st_valid),
      .fire_st_ready     (fire_st_ready),
      .fire_st_addr      (fire_st_addr),
      .fire_st_data      (fire_st_data),
      .fire_st_data_size (fire_st_data_size),
      .fire_st_stq_tag   (fire_st_stq_tag),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_addr      (mem_req_addr),
      .mem_req_data      (mem_req_data),
      .mem_req_be        (mem_req_be),
      .mem_resp_valid    (mem_resp_valid),
      .st_done_valid     (st_done_valid),
      .st_done_stq_tag   (st_done_stq_tag),
      .probe_valid       (probe_valid),
      .probe_addr        (probe_addr),
      .probe_size        (probe_size),
      .probe_hit         (probe_hit),
      .sb_empty          (sb_empty)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size,
                       input logic [STQ_WIDTH-1:0] tag);
      fire_st_valid     = 1'b1;
      fire_st_addr      = addr;
      fire_st_data      = data;
      fire_st_data_size = size;
      fire_st_stq_tag   = tag;
      step();
      fire_st_valid = 1'b0;
   endtask

   task automatic wait_req();
      int k = 0;
      while (!mem_req_valid && k < 20) begin
         step();
         k++;
      end
      check("req_timeout", 64'(k < 20), 64'd1);
   endtask

   // Handshake one write, acknowledge it and check the completion pulse.
   task automatic serve(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                        input logic [STQ_WIDTH-1:0] tag, input logic ready_after);
      wait_req();
      check("req_addr", 64'(mem_req_addr), 64'(addr));
      check("req_be", 64'(mem_req_be), 64'(be));
      check("req_data", 64'(mem_req_data), 64'(data));
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("req_drop", 64'(mem_req_valid), 64'd0);
      step();
      check("no_early_done", 64'(st_done_valid), 64'd0);
      mem_resp_valid = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      check("done_valid", 64'(st_done_valid), 64'd1);
      check("done_tag", 64'(st_done_stq_tag), 64'(tag));
      check("ready_after_pop", 64'(fire_st_ready), 64'(ready_after));
      step();
      check("done_pulse_end", 64'(st_done_valid), 64'd0);
   endtask

   initial begin
      logic [31:0] a0, d0;
      logic [3:0]  b0;
      logic        exp_byte_probe;
`ifdef SB_PROBE_BYTE_EN
      exp_byte_probe = 1'b0;
`else
      exp_byte_probe = 1'b1;
`endif
      step();
      step();
      check("rst_ready", 64'(fire_st_ready), 64'd1);
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_req_addr", 64'(mem_req_addr), 64'd0);
      check("rst_done", 64'(st_done_valid), 64'd0);
      check("rst_empty", 64'(sb_empty), 64'd1);
      rst_n = 1'b1;
      step();

      // 1: byte store at the top lane
      push(32'h1003, 32'hAB, 3'd0, 4'd5);
      check("t1_not_empty", 64'(sb_empty), 64'd0);
      serve(32'h1000, 4'b1000, 32'hAB00_0000, 4'd5, 1'b1);
      check("t1_empty", 64'(sb_empty), 64'd1);

      // 2: fill, hold a fifth, drain in order
      for (int i = 0; i < 4; i++)
         push(32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i), 3'd2, STQ_WIDTH'(i));
      check("t2_full", 64'(fire_st_ready), 64'd0);
      fire_st_valid   = 1'b1;
      fire_st_addr    = 32'h900;
      fire_st_stq_tag = 4'd9;
      step();
      step();
      check("t2_still_full", 64'(fire_st_ready), 64'd0);
      fire_st_valid = 1'b0;
      for (int i = 0; i < 4; i++)
         serve(32'h100 + 32'(4 * i), 4'hF, 32'h1111_1111 * 32'(i), STQ_WIDTH'(i), 1'b1);
      check("t2_drained", 64'(sb_empty), 64'd1);

      // 3: half stores, misaligned half forced to lane 0
      push(32'h2001, 32'h1234, 3'd1, 4'd2);
      push(32'h2002, 32'h1234, 3'd1, 4'd3);
      serve(32'h2000, 4'b0011, 32'h0000_1234, 4'd2, 1'b1);
      serve(32'h2000, 4'b1100, 32'h1234_0000, 4'd3, 1'b1);

      // 4: stall in REQ, spurious ack ignored; size 3 acts as word
      push(32'h4002, 32'hDEAD_BEEF, 3'd3, 4'd7);
      wait_req();
      a0 = mem_req_addr;
      d0 = mem_req_data;
      b0 = mem_req_be;
      check("t4_addr", 64'(a0), 64'h4000);
      check("t4_be", 64'(b0), 64'hF);
      for (int c = 0; c < 5; c++) begin
         mem_resp_valid = (c == 2);
         step();
         mem_resp_valid = 1'b0;
         check("t4_hold_valid", 64'(mem_req_valid), 64'd1);
         check("t4_hold_addr", 64'(mem_req_addr), 64'(a0));
         check("t4_hold_data", 64'(mem_req_data), 64'(d0));
         check("t4_hold_be", 64'(mem_req_be), 64'(b0));
         check("t4_no_done", 64'(st_done_valid), 64'd0);
      end
      serve(32'h4000, 4'hF, 32'hDEAD_BEEF, 4'd7, 1'b1);

      // 5: probe
      push(32'h3000, 32'h55, 3'd0, 4'd1);
      probe_valid = 1'b1;
      probe_addr  = 32'h3002;
      probe_size  = 3'd0;
      #1 check("t5_byte_probe", 64'(probe_hit), 64'(exp_byte_probe));
      probe_size = 3'd2;
      #1 check("t5_word_probe", 64'(probe_hit), 64'd1);
      probe_addr = 32'h3004;
      #1 check("t5_miss", 64'(probe_hit), 64'd0);
      probe_addr  = 32'h3000;
      probe_valid = 1'b0;
      #1 check("t5_no_valid", 64'(probe_hit), 64'd0);
      serve(32'h3000, 4'b0001, 32'h55, 4'd1, 1'b1);
      probe_valid = 1'b1;
      #1 check("t5_after_drain", 64'(probe_hit), 64'd0);
      probe_valid = 1'b0;

      // 6: reset while in WAIT with three entries
      for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 32'(i), 3'd2, STQ_WIDTH'(8 + i));
      wait_req();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_req_valid", 64'(mem_req_valid), 64'd0);
      check("t6_req_addr", 64'(mem_req_addr), 64'd0);
      check("t6_req_data", 64'(mem_req_data), 64'd0);
      check("t6_req_be", 64'(mem_req_be), 64'd0);
      check("t6_empty", 64'(sb_empty), 64'd1);
      check("t6_ready", 64'(fire_st_ready), 64'd1);
      mem_resp_valid = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("t6_no_done", 64'(st_done_valid), 64'd0);
      check("t6_idle", 64'(mem_req_valid), 64'd0);
      push(32'h5000, 32'h77, 3'd0, 4'd6);
      serve(32'h5000, 4'b0001, 32'h77, 4'd6, 1'b1);
      check("t6_final_empty", 64'(sb_empty), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Consumer end of the STQ fire-store interface (fire_st_valid/ready).
- Accepts retired stores drained from the STQ head and holds them in a small in-order FIFO.
- Converts each entry into a byte-enabled, word-aligned write and issues it to the dcache write port, one request outstanding at a time.
- Reports each completed write by STQ tag, which wakes loads sleeping on that store; a probe port lets the load pipe detect stores that have left the STQ but are not yet in the cache.

Parameters:
- SB_DEPTH, 4, buffer entries; power of two, at least 2.
- SB_WIDTH, 2, log2(SB_DEPTH).
- Data width comes from the shared macros: `XLEN = 32, `STQ_WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fire_st_valid  in  1  store request from STQ
fire_st_ready  out  1  buffer can accept
fire_st_addr  in  `XLEN  byte address
fire_st_data  in  `XLEN  store data, LSB-justified
fire_st_data_size  in  3  [1:0] 0=byte, 1=half, 2=word
fire_st_stq_tag  in  `STQ_WIDTH  STQ index of the store
mem_req_valid  out  1  dcache write request
mem_req_ready  in  1  dcache accepts request
mem_req_addr  out  `XLEN  word address, [1:0]=0
mem_req_data  out  32  byte-lane-positioned data
mem_req_be  out  4  byte enables
mem_resp_valid  in  1  write acknowledge, 1-cycle pulse
st_done_valid  out  1  store written to cache
st_done_stq_tag  out  `STQ_WIDTH  tag of the completed store
probe_valid  in  1  load address probe
probe_addr  in  `XLEN  load byte address
probe_hit  out  1  a pending store matches the probe's word
sb_empty  out  1  no entries and FSM idle (fence/drain)

Behaviour:
- Reset values: fire_st_ready=1, mem_req_valid=0, mem_req_addr/data/be=0, st_done_valid=0, st_done_stq_tag=0, probe_hit=0, sb_empty=1, count=0, FSM=IDLE. Reset mid-operation discards every entry, including an in-flight write.
- Push:
  - fire_st_ready = (count != SB_DEPTH), combinational from registered count only; there is no full-bypass even when a pop occurs that cycle.
  - On valid&&ready, write the entry at tail and increment the tail pointer. Pointers are SB_WIDTH bits, wrap naturally, plus a wrap bit.
- Lane formatting at push:
  - Byte: off=addr[1:0], be=4'b0001<<off, data=data[7:0]<<8*off.
  - Half: off={addr[1],0} (forced 2-byte alignment), be=4'b0011<<off.
  - Word: off=0 (forced 4-byte alignment), be=4'hF.
  - Size 3: treated as word.
  - Entry stores {word_addr, data32, be, stq_tag}.
- FSM:
  - IDLE: if count!=0, go to REQ with head entry presented.
  - REQ: mem_req_valid=1; outputs held stable until mem_req_ready; then go to WAIT.
  - WAIT: on mem_resp_valid, pop the head, go to IDLE. mem_resp_valid outside WAIT is ignored.
  - The REQ->WAIT->IDLE->REQ sequence means back-to-back entries cost at least 3 cycles each.
- st_done: registered; pulses for exactly one cycle, the cycle after the ack, carrying the popped tag.
- Simultaneous push and pop: count unchanged.
- There is no flush input: accepted stores are architecturally retired and always drain.
- probe_hit (combinational) = probe_valid && OR over valid entries of (entry.word_addr == probe_addr[`XLEN-1:2]). The head still counts while in REQ or WAIT.
- sb_empty = (count==0) && FSM==IDLE.

Optional Feature:
SB_PROBE_BYTE_EN:
- Defined: the probe also requires byte overlap. Load byte-enables come from a new port probe_size[2:0] using the same lane rules, and probe_hit requires (entry.be & probe_be) != 0.
- Undefined: word-granular match as above; the probe_size port is still present and ignored.

Decomposition:
- Shared package: the MEM_SIZE enum (BYTE/HALF/WORD), an SB_ENTRY struct (word_addr, data, be, stq_tag), a typedef for the FSM state, and a lane-format function (size, addr, data -> be, data) reused by the STQ/LSU.
- One sub-module, sb_fifo: storage, pointers, count, full/empty, with head read and per-entry word_addr/be exported for the probe.
- FSM, formatting and probe stay in the top.

Test Plan:
1. Reset, then push byte st addr=0x1003 data=0xAB tag=5 with mem_req_ready=1 -> mem_req_addr=0x1000, be=4'b1000, data=0xAB000000. Ack 2 cycles later -> st_done_valid pulse with tag=5 the following cycle; sb_empty=1.
2. Push 4 stores (tags 0-3) with mem_req_ready=0 -> fire_st_ready=0 after the 4th push. A 5th fire_st_valid is held and not accepted. Release ready and ack -> st_done tags come out in order 0,1,2,3, and ready reasserts the cycle after the first pop.
3. Half store addr=0x2001 data=0x1234 -> be=4'b0011, data=0x00001234. Half store at addr=0x2002 -> be=4'b1100, data=0x12340000.
4. Hold mem_req_ready=0 for 5 cycles -> addr/data/be stay stable every cycle and no pop occurs. Spurious mem_resp_valid while in REQ -> ignored.
5. Entry at 0x3000 pending -> probe 0x3002 hits. Probe 0x3004 misses. With SB_PROBE_BYTE_EN, a byte store at 0x3000 and a byte probe at 0x3002 -> miss.
6. Assert rst_n low while in WAIT with 3 entries -> all outputs return to reset values, no st_done is issued, and the next push starts from an empty buffer.
